// File: rtl/div_unit_if.sv
// ============================================================================
//  div_unit_if : request/response bundle between the execute stage and div_unit
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready
  );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
//  div_unit : iterative radix-2 restoring divider for MIPS DIV/DIVU ({HI,LO})
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  wire logic   clk,
  input  wire logic   rst,
  div_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DIVZERO = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       shifted, trial;
  logic                 step_ok;
  logic [WIDTH-1:0]     rem_step, quo_step;
  logic                 last_step;

  assign a_neg = bus.signed_div & bus.opdata1[WIDTH-1];
  assign b_neg = bus.signed_div & bus.opdata2[WIDTH-1];
  assign abs_a = a_neg ? -bus.opdata1 : bus.opdata1;
  assign abs_b = b_neg ? -bus.opdata2 : bus.opdata2;

  // Remainder stays below the divisor, so WIDTH+1 bits hold the trial exactly.
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign step_ok  = ~trial[WIDTH];
  assign rem_step = step_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {dvd_q[WIDTH-2:0], step_ok};
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    if (bus.annul) begin
      state_d = IDLE;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvd_d     = abs_a;
            dvs_d     = abs_b;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = (bus.opdata2 == '0) ? DIVZERO : BUSY;
          end
        end
        BUSY: begin
          rem_d = rem_step;
          dvd_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            result_d = {neg_rem_q ? -rem_step : rem_step,
                        neg_quo_q ? -quo_step : quo_step};
            ready_d  = 1'b1;
            state_d  = DONE;
          end
        end
        DIVZERO: begin
          result_d = '0;
          ready_d  = 1'b1;
          state_d  = DONE;
        end
        DONE: begin
          if (!bus.start) begin
            ready_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  tb_div_unit : scoreboard bench for div_unit with directed DIV/DIVU vectors
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus();

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [63:0] res;
    int          edge_no;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_ready = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every rising ready must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (bus.ready && !prev_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1 at edge %0d expected no pending op", cyc);
      end else begin
        cur = sb.pop_front();
        check64({cur.name, " result"}, bus.result, cur.res);
        check64({cur.name, " latency"}, 64'(cyc), 64'(cur.edge_no));
      end
    end
    prev_ready = bus.ready;
  end

  // Called at a negedge; the accepting edge is counted as edge 1.
  task automatic issue(input string nm, input logic sd, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int lat);
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.opdata1    = a;
    bus.opdata2    = b;
    sb.push_back('{res: exp, edge_no: cyc + lat, name: nm});
    @(negedge clk);
    bus.opdata1    = $urandom;
    bus.opdata2    = $urandom;
    bus.signed_div = ~sd;
  endtask

  task automatic finish_op(input string nm, input logic [63:0] exp);
    int n;
    n = 0;
    while (!bus.ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got ready=0 expected ready within 60 cycles", nm);
    end
    @(negedge clk);
    check64({nm, " hold_ready"}, 64'(bus.ready), 64'd1);
    check64({nm, " hold_result"}, bus.result, exp);
    bus.start = 1'b0;
    @(negedge clk);
    check64({nm, " drop_ready"}, 64'(bus.ready), 64'd0);
    check64({nm, " kept_result"}, bus.result, exp);
  endtask

  task automatic run(input string nm, input logic sd, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp, input int lat);
    issue(nm, sd, a, b, exp, lat);
    finish_op(nm, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;

    repeat (2) @(negedge clk);
    check64("reset ready", 64'(bus.ready), 64'd0);
    check64("reset result", bus.result, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run("udiv_100_7",   1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},       33);
    run("sdiv_m7_2",    1'b1, 32'hFFFF_FFF9,  32'h2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run("sdiv_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    run("sdiv_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0,        32'h8000_0000}, 33);
    run("udiv_big",     1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'h0},        33);
    run("div_zero",     1'b1, 32'd1234,       32'd0,        64'd0,                          2);
    run("udiv_9_3",     1'b0, 32'd9,          32'd3,        {32'd0,        32'd3},        33);

    // Abandon a divide mid-flight; nothing must be reported for it.
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd123; bus.opdata2 = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    check64("annul ready", 64'(bus.ready), 64'd0);
    check64("annul result_kept", bus.result, {32'd0, 32'd3});
    run("udiv_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);

    // Annul must beat a simultaneous start in IDLE.
    bus.start = 1'b1; bus.annul = 1'b1; bus.opdata1 = 32'd5; bus.opdata2 = 32'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b0;
    repeat (4) @(negedge clk);
    check64("annul_vs_start ready", 64'(bus.ready), 64'd0);

    // Asynchronous reset in the middle of a divide.
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check64("async_rst ready", 64'(bus.ready), 64'd0);
    check64("async_rst result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run("udiv_1000_10", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);

    repeat (3) @(negedge clk);
    check64("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle divider that sits beside the execute stage.
- Serves MIPS DIV and DIVU; produces {remainder, quotient} for the HI/LO write path.
- Its `result` drives the ALU's `div_res` input. Its `ready`, registered through E and M, forms the ALU's `div_readyE`/`div_readyM`.
- The ALU holds `stall_div` while a divide is outstanding. This block runs one radix-2 restoring step per cycle.

Parameters:
- WIDTH, 32, operand width in bits; `result` is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; forces IDLE.
- start  input  1  divide requested; execute stage holds a DIV/DIVU op.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1  input  WIDTH  dividend (rs).
- opdata2  input  WIDTH  divisor (rt).
- annul  input  1  pipeline flush or exception; abandons the current operation.
- result  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}, i.e. {HI, LO}.
- ready  output  1  `result` is valid for the accepted operation.

Behaviour:
- Reset (rst=0, async): state=IDLE, ready=0, result=0, counter=0, internal registers=0.
- States and transitions:
  - IDLE → DIVZERO when start=1, annul=0 and opdata2==0.
  - IDLE → BUSY when start=1, annul=0 and opdata2!=0.
  - BUSY → DONE when counter==WIDTH-1.
  - DIVZERO → DONE.
  - DONE → IDLE when start=0.
  - Any state → IDLE when annul=1. Annul has priority over every other transition, including start in IDLE.
- Accept (IDLE edge):
  - Latch the magnitudes: |opdata1| and |opdata2| if signed_div=1 and the operand MSB is set; otherwise the raw value.
  - Latch neg_q = signed_div & (opdata1 MSB ^ opdata2 MSB), and neg_r = signed_div & opdata1 MSB.
  - Clear the partial remainder and counter.
  - Operands are sampled only on this edge; later changes on opdata1/opdata2/signed_div are ignored.
- BUSY, each edge:
  - Shift {partial remainder, dividend} left by one.
  - Trial-subtract the divisor in WIDTH+1 bits.
  - If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - counter += 1.
- BUSY→DONE edge:
  - Register result = {neg_r ? -rem : rem, neg_q ? -quo : quo}, modulo 2^WIDTH.
  - Set ready=1.
- DIVZERO→DONE edge: result=0, ready=1. Architecturally unpredictable; fixed at 0 for determinism.
- Latency:
  - Non-zero divisor: ready rises on the WIDTH+1 th edge after the accepting edge (33 for WIDTH=32).
  - Zero divisor: ready rises on the 2nd edge.
- DONE:
  - ready=1 and result are held stable while start=1.
  - On the first edge with start=0, ready falls to 0 and state=IDLE; result retains its last value.
  - A new start is not accepted in the same edge that leaves DONE.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000 and remainder 0, via natural wrap. No trap.
- Annul:
  - From BUSY/DIVZERO: ready stays 0 and result is unchanged.
  - From DONE: ready falls next edge.
  - A start may be accepted on the edge after returning to IDLE.
- Annul on the same edge as the last BUSY step: annul wins, so no ready pulse occurs.
- Reset mid-operation: immediate return to the reset values, with no partial result exposed.
- ready is a registered output with no combinational path from inputs. result is registered.

Test Plan:
- Unsigned 100/7 (signed_div=0), start held → ready=1 on edge 33, result={32'd2, 32'd14}; start dropped → ready=0 one edge later.
- Signed -7/2 (0xFFFFFFF9 / 0x2) → result={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2 → {0x00000001, 0xFFFFFFFD}.
- 0x80000000 / 0xFFFFFFFF: signed → {0x00000000, 0x80000000}; unsigned → {0x80000000, 0x00000000}.
- Divisor 0 → ready on edge 2, result=0. Then, after start is deasserted, 9/3 → ready on edge 33, result={0, 3}.
- annul=1 on cycle 10 of BUSY → ready never asserts and state=IDLE. Restart 50/5 on the following edge → {0, 10} after 33 edges.
- rst driven low asynchronously mid-BUSY (between clock edges) → ready=0 and result=0 immediately. After release, a new divide completes correctly.
